mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/arb_watchdog.sv | 27 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM port status, arbiter states, data word,
// and the fetch/data fairness pick used when leaving IDLE.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WD_W   = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // Data has priority, except a fetch that already lost the last contention wins now
  function automatic arb_state_t pick_grant(input logic ireq, input logic dreq,
                                            input arb_state_t last_grant);
    arb_state_t g;
    g = IDLE;
    if (ireq && dreq && (last_grant == DGRANT)) g = IGRANT;
    else if (dreq)                              g = DGRANT;
    else if (ireq)                              g = IGRANT;
    return g;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts stalled grant cycles and flags expiry on the TIMEOUT_CYCLES-th one.
// Only instantiated when MEM_ARBITER_TIMEOUT_EN is defined.
module arb_watchdog
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WD_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + WD_W'(1);
    end
  end

  assign expired = count_en && (count == WD_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single shared RAM port with alternating fairness.
// Optional grant watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iREN,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       iwait,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dwait,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate,
  output logic       err,
  output logic       timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("mem_arbiter: TIMEOUT_CYCLES must lie in 2..255");
  end

  arb_state_t state, last_grant, next_grant;
  ramstate_t  rs;
  logic ireq, dreq, grant, owner_req, live;
  logic access_hit, error_hit, timeout_hit, finish;
  logic err_q, timeout_q;

  assign rs         = ramstate_t'(ramstate);
  assign ireq       = iREN;
  assign dreq       = dREN | dWEN;
  assign grant      = (state != IDLE);
  assign next_grant = pick_grant(ireq, dreq, last_grant);

  always_comb begin
    owner_req = 1'b0;
    case (state)
      IGRANT:  owner_req = ireq;
      DGRANT:  owner_req = dreq;
      default: owner_req = 1'b0;
    endcase
  end

  // A grant only counts as active while its owner keeps requesting
  assign live       = grant & owner_req;
  assign access_hit = live & (rs == ACCESS);
  assign error_hit  = live & (rs == ERROR);

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic stalled;
  assign stalled = live & ((rs == FREE) | (rs == BUSY));

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (~grant),
    .count_en(stalled),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign finish = access_hit | error_hit | timeout_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= IGRANT;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (error_hit)   err_q     <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
      case (state)
        IDLE: begin
          state <= next_grant;
          if (next_grant != IDLE) last_grant <= next_grant;
        end
        default: begin
          if (!owner_req || finish) state <= IDLE;
        end
      endcase
    end
  end

  // RAM drive and requester returns follow the current grant combinationally
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = ~dWEN;
      end
      default: ;
    endcase
  end

  assign iload   = ((state == IGRANT) && access_hit) ? ramload : '0;
  assign dload   = ((state == DGRANT) && access_hit) ? ramload : '0;
  assign iwait   = ireq & ~((state == IGRANT) & finish);
  assign dwait   = dreq & ~((state == DGRANT) & finish);
  assign err     = err_q | error_hit;
  assign timeout = timeout_q | timeout_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against
// a transaction-level owner model. Honours MEM_ARBITER_TIMEOUT_EN like the design.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err, timeout;
  logic [1:0]  ramstate;

  int vectors = 0;
  int miscompares = 0;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TO_M = 4;

  mem_arbiter #(.TIMEOUT_CYCLES(TO_M)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1; step(); step(); RST = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1; iREN = 1; dREN = 1; ramstate = 2'd2;
    step(); step(); samp();
    vectors++;
    if ({ramREN, ramWEN, err, timeout} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_outputs got=%b exp=0000", {ramREN, ramWEN, err, timeout});
    end
    vectors++;
    if (ramaddr !== 32'h0) begin
      miscompares++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr);
    end
    step(); samp();
    vectors++;
    if ({iwait, dwait, ramREN} !== 3'b110) begin
      miscompares++; $display("FAIL reset_held got=%b exp=110", {iwait, dwait, ramREN});
    end
    RST = 0; idle_inputs();
    step();
  endtask

  task automatic test_fetch();
    do_reset();
    iREN = 1; iaddr = 32'h100; ramstate = 2'd1;
    samp();
    vectors++;
    if ({ramREN, iwait} !== 2'b01) begin
      miscompares++; $display("FAIL fetch_idle got=%b exp=01", {ramREN, iwait});
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin ramstate = 2'd2; ramload = 32'hDEADBEEF; end
      samp();
      vectors++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100) begin
        miscompares++; $display("FAIL fetch_drive c%0d got=%b%b %h exp=10 100", c, ramREN, ramWEN, ramaddr);
      end
      vectors++;
      if (iwait !== (c != 3) || iload !== ((c == 3) ? 32'hDEADBEEF : 32'h0)) begin
        miscompares++; $display("FAIL fetch_ret c%0d got=%b %h", c, iwait, iload);
      end
    end
    step(); iREN = 0; ramstate = 2'd0; samp();
    vectors++;
    if ({ramREN, iload} !== {1'b0, 32'h0}) begin
      miscompares++; $display("FAIL fetch_done got=%b %h exp=0 0", ramREN, iload);
    end
  endtask

  task automatic test_contention();
    int exp_own [8];
    logic [31:0] ea;
    exp_own = '{0, 2, 0, 1, 0, 2, 0, 1};
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h80; ramstate = 2'd2; ramload = 32'hA5A5_0001;
    for (int c = 0; c < 8; c++) begin
      samp();
      ea = (exp_own[c] == 1) ? 32'h40 : (exp_own[c] == 2) ? 32'h80 : 32'h0;
      vectors++;
      if (ramaddr !== ea || iwait !== (exp_own[c] != 1) || dwait !== (exp_own[c] != 2)) begin
        miscompares++;
        $display("FAIL contention c%0d got=%h %b%b exp=%h %b%b", c, ramaddr, iwait, dwait,
                 ea, exp_own[c] != 1, exp_own[c] != 2);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_store();
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; ramstate = 2'd1;
    step(); samp();
    vectors++;
    if ({ramWEN, ramREN, dwait} !== 3'b101 || ramstore !== 32'h12345678 || ramaddr !== 32'h200) begin
      miscompares++; $display("FAIL store_drive got=%b%b%b %h %h", ramWEN, ramREN, dwait, ramstore, ramaddr);
    end
    step(); ramstate = 2'd2; samp();
    vectors++;
    if (dwait !== 1'b0) begin
      miscompares++; $display("FAIL store_done got=%b exp=0", dwait);
    end
    step(); dREN = 0; dWEN = 0; ramstate = 2'd0; samp();
    vectors++;
    if ({ramWEN, ramREN} !== 2'b00) begin
      miscompares++; $display("FAIL store_idle got=%b exp=00", {ramWEN, ramREN});
    end
  endtask

  task automatic test_error();
    do_reset();
    iREN = 1; iaddr = 32'h300; ramstate = 2'd1;
    step(); ramstate = 2'd3; ramload = 32'hFFFFFFFF; samp();
    vectors++;
    if ({iwait, err} !== 2'b01 || iload !== 32'h0) begin
      miscompares++; $display("FAIL error_hit got=%b%b %h exp=01 0", iwait, err, iload);
    end
    step(); iREN = 0; ramstate = 2'd0; samp();
    vectors++;
    if ({err, ramREN} !== 2'b10) begin
      miscompares++; $display("FAIL error_idle got=%b exp=10", {err, ramREN});
    end
    step(); samp();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL error_sticky got=%b exp=1", err);
    end
    RST = 1; step(); RST = 0; samp();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL error_clear got=%b exp=0", err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dREN = 1; daddr = 32'h400; ramstate = 2'd1;
    step(); samp();
    vectors++;
    if (ramREN !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_grant got=%b exp=1", ramREN);
    end
    RST = 1; ramload = 32'h5555AAAA;
    step(); samp();
    vectors++;
    if ({ramREN, ramWEN, dwait} !== 3'b001 || dload !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_abort got=%b %h exp=001 0", {ramREN, ramWEN, dwait}, dload);
    end
    step(); samp();
    vectors++;
    if (ramREN !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_held got=%b exp=0", ramREN);
    end
    RST = 0; idle_inputs(); step();
  endtask

  task automatic test_timeout();
    do_reset();
    dREN = 1; daddr = 32'h500; ramstate = 2'd1;
    step();
    if (TMO_EN) begin
      for (int c = 1; c <= 4; c++) begin
        samp();
        vectors++;
        if ({dwait, timeout} !== ((c == 4) ? 2'b01 : 2'b10)) begin
          miscompares++; $display("FAIL timeout_c%0d got=%b exp=%b", c, {dwait, timeout},
                                  (c == 4) ? 2'b01 : 2'b10);
        end
        step();
      end
      dREN = 0; samp();
      vectors++;
      if ({timeout, ramREN} !== 2'b10) begin
        miscompares++; $display("FAIL timeout_sticky got=%b exp=10", {timeout, ramREN});
      end
    end else begin
      for (int c = 0; c < 100; c++) begin
        samp();
        vectors++;
        if ({dwait, timeout, ramREN} !== 3'b101) begin
          miscompares++; $display("FAIL notimeout_c%0d got=%b exp=101", c, {dwait, timeout, ramREN});
        end
        step();
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    int own, wd, r;
    bit last_data, err_m, to_m, live, tmo_hit, fin;
    logic [31:0] e_addr, e_il, e_dl;
    do_reset();
    own = 0; wd = 0; last_data = 0; err_m = 0; to_m = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) iREN = ~iREN;
      if ($urandom_range(0, 5) == 0) dREN = ~dREN;
      if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 19);
      ramstate = (r < 2) ? 2'd0 : (r < 11) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
      samp();
      live    = (own == 1 && iREN) || (own == 2 && (dREN || dWEN));
      tmo_hit = TMO_EN && live && (ramstate < 2) && (wd == TO_M - 1);
      fin     = live && (ramstate >= 2 || tmo_hit);
      e_addr  = (own == 1) ? iaddr : (own == 2) ? daddr : 32'h0;
      e_il    = (own == 1 && live && ramstate == 2) ? ramload : 32'h0;
      e_dl    = (own == 2 && live && ramstate == 2) ? ramload : 32'h0;
      vectors++;
      if ({ramREN, ramWEN} !== {own == 1 || (own == 2 && !dWEN), own == 2 && dWEN} || ramaddr !== e_addr) begin
        miscompares++; $display("FAIL rnd_ram c%0d own=%0d got=%b%b %h exp_addr=%h", c, own, ramREN, ramWEN, ramaddr, e_addr);
      end
      vectors++;
      if (own != 1 && ramstore !== ((own == 2) ? dstore : 32'h0)) begin
        miscompares++; $display("FAIL rnd_store c%0d own=%0d got=%h", c, own, ramstore);
      end
      vectors++;
      if (iwait !== (iREN && !(own == 1 && fin)) || dwait !== ((dREN || dWEN) && !(own == 2 && fin))) begin
        miscompares++; $display("FAIL rnd_wait c%0d own=%0d got=%b%b", c, own, iwait, dwait);
      end
      vectors++;
      if (iload !== e_il || dload !== e_dl) begin
        miscompares++; $display("FAIL rnd_load c%0d got=%h %h exp=%h %h", c, iload, dload, e_il, e_dl);
      end
      vectors++;
      if (err !== (err_m || (live && ramstate == 3)) || timeout !== (to_m || tmo_hit)) begin
        miscompares++; $display("FAIL rnd_flags c%0d got=%b%b", c, err, timeout);
      end
      if (own == 0) begin
        if (iREN && (dREN || dWEN)) own = last_data ? 1 : 2;
        else if (dREN || dWEN)      own = 2;
        else if (iREN)              own = 1;
        if (own != 0) begin last_data = (own == 2); wd = 0; end
      end else begin
        if (live && ramstate == 3) err_m = 1;
        if (tmo_hit) to_m = 1;
        if (!live || fin) own = 0;
        else wd++;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_error();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
